// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the single-port RAM master: FSM encoding and default geometry.
// The RAM instance uses the same default geometry constants.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_SIZE = 10;
  localparam int DEF_WORD_SIZE = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    TURN    = 3'd4
  } state_t;

endpackage

// File: rtl/sram_master_ctrl.sv
// Single-transaction master for the single-port synchronous RAM.
// Turns a valid/ready request into registered cs/r/w/addr strobes and owns the shared data bus.
module sram_master_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic                 mem_cs,
  output logic                 mem_r,
  output logic                 mem_w,
  output logic [ADDR_SIZE-1:0] mem_addr,
  inout  wire  [WORD_SIZE-1:0] mem_data
);

  state_t               state;
  logic                 drive_en;
  logic [WORD_SIZE-1:0] wdata_q;

  // The bus is driven only while a write strobe is up.
  assign mem_data = drive_en ? wdata_q : {WORD_SIZE{1'bz}};

  // Write data is pure datapath: captured on the accept edge, never reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid && req_we) begin
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_cs    <= 1'b0;
      mem_r     <= 1'b0;
      mem_w     <= 1'b0;
      mem_addr  <= '0;
      drive_en  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            mem_cs    <= 1'b1;
            mem_addr  <= req_addr;
            if (req_we) begin
              state    <= WR;
              mem_w    <= 1'b1;
              drive_en <= 1'b1;
            end else begin
              state    <= RD_ADDR;
              mem_r    <= 1'b1;
            end
          end
        end
        WR: begin
          state     <= IDLE;
          mem_cs    <= 1'b0;
          mem_w     <= 1'b0;
          drive_en  <= 1'b0;
          req_ready <= 1'b1;
        end
        RD_ADDR: begin
          state <= RD_DATA;
        end
        RD_DATA: begin
          // The RAM is driving the bus during this cycle; capture on its closing edge.
          state     <= TURN;
          rsp_rdata <= mem_data;
          rsp_valid <= 1'b1;
          mem_cs    <= 1'b0;
          mem_r     <= 1'b0;
        end
        TURN: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_cs    <= 1'b0;
          mem_r     <= 1'b0;
          mem_w     <= 1'b0;
          drive_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_master_ctrl.sv
// Bench for sram_master_ctrl: behavioural RAM responder, scoreboard queue and protocol monitor.
module tb_sram_master_ctrl;
  import sram_ctrl_pkg::*;

  localparam int AW = DEF_ADDR_SIZE;
  localparam int DW = DEF_WORD_SIZE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          mem_cs, mem_r, mem_w;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;

  sram_master_ctrl #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_cs(mem_cs), .mem_r(mem_r), .mem_w(mem_w),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // RAM responder: latches on the edge ending RD_ADDR, drives only during RD_DATA
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;
  logic          ram_oe = 1'b0;
  always @(posedge clk) begin
    if (mem_cs && mem_w) ram[mem_addr] <= mem_data;
    if (mem_cs && mem_r) ram_q <= ram[mem_addr];
    ram_oe <= mem_cs && mem_r && !ram_oe;
  end
  assign mem_data = ram_oe ? ram_q : {DW{1'bz}};

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;
  logic [DW-1:0] sh [0:63];
  bit            wr_done [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops plus per-cycle protocol checks
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=1 rsp_rdata=%0h but no read pending", rsp_rdata);
        end else begin
          mon_e = q.pop_front();
          chk($sformatf("rsp_data@%0h", mon_e.addr), 32'(rsp_rdata), 32'(mon_e.data));
          chk($sformatf("rsp_latency@%0h", mon_e.addr), 32'(cyc), 32'(mon_e.cyc));
        end
      end
      if (mem_cs || rsp_valid) chk("ready_low_busy", 32'(req_ready), 32'd0);
      if (mem_r || mem_w) begin
        chk("strobe_excl", 32'(mem_r && mem_w), 32'd0);
        chk("strobe_needs_cs", 32'(mem_cs), 32'd1);
      end
      if (mem_cs) chk("mem_addr", 32'(mem_addr), 32'(last_addr));
      if (mem_w) chk("wr_bus", 32'(mem_data), 32'(last_wdata));
      if (mem_r && ram_oe) chk("rd_bus_no_x", 32'($isunknown(mem_data)), 32'd0);
    end
  end

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int acc);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready=0 after 40 cycles, addr %0h", a);
      req_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      if (!we) q.push_back('{data: d, cyc: cyc + 3, addr: a});
      @(posedge clk);
      last_addr  = a;
      last_wdata = d;
      #1;
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3;
    int idx;
    logic we;
    logic [DW-1:0] d;

    // Reset state
    #12;
    chk("rst_cs", 32'(mem_cs), 32'd0);
    chk("rst_r", 32'(mem_r), 32'd0);
    chk("rst_w", 32'(mem_w), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);

    // Single write then read
    issue(1'b1, 10'h155, 8'hA5, a0);
    issue(1'b0, 10'h155, 8'hA5, a1);
    chk("wr_occupancy", 32'(a1 - a0), 32'd2);
    idle(5);

    // Back-to-back with req_valid held high
    issue(1'b1, 10'h001, 8'h11, a0);
    issue(1'b0, 10'h001, 8'h11, a1);
    issue(1'b1, 10'h002, 8'h22, a2);
    issue(1'b0, 10'h002, 8'h22, a3);
    chk("rd_occupancy", 32'(a2 - a1), 32'd4);
    chk("wr_to_rd", 32'(a3 - a2), 32'd2);
    idle(5);

    // Boundary addresses
    issue(1'b1, 10'h000, 8'hFF, a0);
    issue(1'b1, 10'h3FF, 8'h00, a0);
    issue(1'b0, 10'h000, 8'hFF, a0);
    issue(1'b0, 10'h3FF, 8'h00, a0);
    idle(5);

    // Reset during RD_DATA
    issue(1'b0, 10'h155, 8'hA5, a0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("in_rd_data_r", 32'(mem_cs && mem_r), 32'd1);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_cs", 32'(mem_cs), 32'd0);
    chk("midrst_r", 32'(mem_r), 32'd0);
    chk("midrst_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    issue(1'b0, 10'h155, 8'hA5, a0);
    issue(1'b0, 10'h3FF, 8'h00, a0);
    idle(5);

    // Reset during WR to a scratch address
    issue(1'b1, 10'h3AB, 8'h5C, a0);
    req_valid = 1'b0;
    chk("in_wr", 32'(mem_cs && mem_w), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("wrrst_w", 32'(mem_w), 32'd0);
    chk("wrrst_cs", 32'(mem_cs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    issue(1'b0, 10'h001, 8'h11, a0);
    idle(5);

    // Random traffic in a 64-word window at 0x200
    for (int i = 0; i < 64; i++) wr_done[i] = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      idx = int'($urandom_range(0, 63));
      we  = ($urandom_range(0, 1) == 1) || !wr_done[idx];
      d   = we ? 8'($urandom_range(0, 255)) : sh[idx];
      if (we) begin
        sh[idx] = d;
        wr_done[idx] = 1'b1;
      end
      issue(we, 10'h200 + 10'(idx), d, a0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(8);
    chk("pending_rsp", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
